video_chan_select: RTL and testbench
====================================

Name: video_chan_select

Overview:
- Parametrised successor to the fixed NV/MTI/simulate bit-stream selector.
- Selects one of NCH thresholded video bit streams (NV manual, NV CFAR, MTI, future channels) per range cell, using a runtime-loaded range-zone table.
- Delays the matching adc_done strobe and counts per-sweep hits on the selected stream.
- Sits between the per-channel threshold paths and the data-processing (sliding-window) unit; config changes are applied only at sweep boundaries.

Parameters:
- NCH, 4, number of input bit-stream channels (2..8).
- CW, 2, channel index width; must satisfy 2**CW >= NCH.
- RW, 10, range-cell counter width.
- NZ, 4, number of range zones in the selection table (1..8).
- ZW, 2, zone index width; must satisfy 2**ZW >= NZ.
- DLY, 3, pipeline stages applied to the selected adc_done strobe (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pros  in  1  sweep-active flag from decode; its falling edge marks the sweep boundary
- range  in  RW  current range cell, stable while that cell's adc_done is high
- bits  in  NCH  per-channel thresholded bit for the current cell
- adc_done  in  NCH  per-channel conversion-done strobe, one clk wide
- sim_bit  in  1  simulated target bit
- cfg_we  in  1  zone-table write strobe
- cfg_zone  in  ZW  zone index being written
- cfg_bound  in  RW  exclusive upper range bound of the zone
- cfg_ch  in  CW  channel assigned to the zone
- mode  in  2  0 = manual, 1 = zone table, 2 = simulate, 3 = manual
- man_ch  in  CW  channel used in manual mode
- bit_out  out  1  selected bit to data processing
- done_out  out  1  selected adc_done, delayed by DLY cycles
- cur_ch  out  CW  channel currently in use
- hit_cnt  out  16  hit count of the previous sweep
- hit_valid  out  1  one-cycle pulse when hit_cnt updates

Behaviour:
- Reset values:
  - All outputs 0.
  - Shadow and active tables: bound = all ones, ch = 0.
  - Active mode = 0, active man_ch = 0, hit counter = 0.
- Boundary detect: pros is registered twice (p1 <= pros, p2 <= p1). bnd = p2 & ~p1, a one-clk pulse 2 cycles after the pros falling edge.
- Shadow config:
  - cfg_we writes {cfg_bound, cfg_ch} into shadow[cfg_zone].
  - mode and man_ch are sampled continuously into shadow registers.
  - cfg_zone >= NZ: write ignored.
- Active load:
  - On bnd, the whole shadow set (table, mode, man_ch) copies to active.
  - If cfg_we coincides with bnd, active receives the pre-write shadow value; the write lands in shadow only and takes effect at the next boundary.
- Channel select, evaluated combinationally on the active set:
  - mode 0/3: sel = man_ch.
  - mode 1: sel = ch of the lowest zone z with range < bound[z]; if no zone matches, use ch[NZ-1].
  - mode 2: sel = man_ch for the done path; the bit path is replaced by sim_bit.
  - sel >= NCH: treated as channel 0.
- Bit path:
  - bit_out registered: bit_out(t+1) = (mode 2 ? sim_bit : bits[sel])(t).
  - cur_ch(t+1) = sel(t).
- Done path: done_out = adc_done[sel] passed through a DLY-stage shift register. Latency is exactly DLY clks; back-to-back strobes are preserved.
- Hit counter:
  - Increments when done_out = 1 and the bit_out value latched at that strobe's cycle (bit_out delayed DLY-1 stages alongside) = 1.
  - Saturates at 16'hFFFF.
  - On bnd: hit_cnt <= counter (including a hit in the same cycle), hit_valid = 1 for one clk, counter <= 0.
- Reset mid-sweep: everything returns to reset values immediately. The first bnd after release loads whatever config is in shadow.

Optional Feature:
- Macro VCS_ZONE_HYST_EN.
- When defined, in mode 1 a change of the zone-derived channel is only accepted after the new channel has been computed on 2 consecutive adc_done[sel] strobes; until then cur_ch/sel hold the previous channel.
- The hysteresis state clears on bnd and on reset.
- Modes 0/2/3 are unaffected.
- When undefined, zone changes take effect on the next clk.

Test Plan:
- Zone lookup:
  - Setup: bounds {159,400,800,1023}, ch {2,0,1,3}, mode 1, boundary applied.
  - Stimulus: range 100, 159, 500, 1023, with adc_done pulses.
  - Required: cur_ch 2, 0, 1, 3 (range 1023 falls in no zone, so it uses ch[NZ-1]); bit_out follows bits[cur_ch] 1 clk later.
- Deferred config:
  - Stimulus: write zone0 ch=1 mid-sweep.
  - Required: cur_ch stays 2 until bnd (2 clks after pros falls), then 1.
  - Stimulus: a write coincident with bnd.
  - Required: it is not applied until the following boundary.
- Done latency (DLY=3):
  - Stimulus: adc_done[sel] pulses at cycles 10 and 11.
  - Required: done_out high at cycles 13 and 14. Pulses on non-selected channels produce no output.
- Hit count:
  - Stimulus: 37 strobes with selected bit = 1 and 20 with bit = 0, then a boundary.
  - Required: hit_cnt = 37 with a 1-clk hit_valid; the next sweep starts from 0. A forced 70000 hits reads 16'hFFFF.
- Simulate mode:
  - Stimulus: mode 2, sim_bit toggling, bits = 0.
  - Required: bit_out mirrors sim_bit delayed by 1 clk.
- Reset mid-sweep:
  - Stimulus: assert reset during an active sweep with a nonzero hit count.
  - Required: all outputs 0 immediately; table back to defaults (sel = 0 in zone mode).

Source files
------------

// File: rtl/video_chan_select.sv
// Per-range-cell channel selector: picks one of NCH thresholded video streams from a zone table,
// delays the matching adc_done strobe and counts per-sweep hits. Optional macro: VCS_ZONE_HYST_EN.
module video_chan_select #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int RW  = 10,
    parameter int NZ  = 4,
    parameter int ZW  = 2,
    parameter int DLY = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pros,
    input  logic [RW-1:0]  range,
    input  logic [NCH-1:0] bits,
    input  logic [NCH-1:0] adc_done,
    input  logic           sim_bit,
    input  logic           cfg_we,
    input  logic [ZW-1:0]  cfg_zone,
    input  logic [RW-1:0]  cfg_bound,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [1:0]     mode,
    input  logic [CW-1:0]  man_ch,
    output logic           bit_out,
    output logic           done_out,
    output logic [CW-1:0]  cur_ch,
    output logic [15:0]    hit_cnt,
    output logic           hit_valid
);

    localparam logic [CW:0] NCH_L = (CW+1)'(NCH);
    localparam logic [ZW:0] NZ_L  = (ZW+1)'(NZ);

    // Channel indices beyond the populated inputs fall back to channel 0
    function automatic logic [CW-1:0] safe_ch(input logic [CW-1:0] c);
        return ({1'b0, c} < NCH_L) ? c : '0;
    endfunction

    logic           p1_q, p1_d, p2_q, p2_d, bnd;
    logic [RW-1:0]  sh_bound_q [NZ];
    logic [RW-1:0]  sh_bound_d [NZ];
    logic [CW-1:0]  sh_ch_q    [NZ];
    logic [CW-1:0]  sh_ch_d    [NZ];
    logic [RW-1:0]  act_bound_q [NZ];
    logic [RW-1:0]  act_bound_d [NZ];
    logic [CW-1:0]  act_ch_q    [NZ];
    logic [CW-1:0]  act_ch_d    [NZ];
    logic [1:0]     sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [CW-1:0]  sh_man_q, sh_man_d, act_man_q, act_man_d;
    logic [CW-1:0]  zone_ch, zone_sel, raw_sel, sel_ch;
    logic [CW-1:0]  cur_ch_q, cur_ch_d;
    logic [DLY-1:0] bit_pipe_q, bit_pipe_d, done_pipe_q, done_pipe_d;
    logic           bit_sel, done_sel, hit;
    logic [15:0]    cnt_q, cnt_d, cnt_inc, hit_cnt_q, hit_cnt_d;
    logic           hit_valid_q, hit_valid_d;

    assign p1_d = pros;
    assign p2_d = p1_q;
    assign bnd  = p2_q & ~p1_q;

    // Shadow set is written freely; the active set only changes at a sweep boundary
    always_comb begin
        sh_bound_d  = sh_bound_q;
        sh_ch_d     = sh_ch_q;
        sh_mode_d   = mode;
        sh_man_d    = man_ch;
        act_bound_d = act_bound_q;
        act_ch_d    = act_ch_q;
        act_mode_d  = act_mode_q;
        act_man_d   = act_man_q;
        if (cfg_we && ({1'b0, cfg_zone} < NZ_L)) begin
            sh_bound_d[cfg_zone] = cfg_bound;
            sh_ch_d[cfg_zone]    = cfg_ch;
        end
        if (bnd) begin
            act_bound_d = sh_bound_q;
            act_ch_d    = sh_ch_q;
            act_mode_d  = sh_mode_q;
            act_man_d   = sh_man_q;
        end
    end

    // Lowest matching zone wins, so scan from the top down
    always_comb begin
        zone_ch = act_ch_q[NZ-1];
        for (int z = NZ - 1; z >= 0; z--) begin
            if (range < act_bound_q[z]) begin
                zone_ch = act_ch_q[z];
            end
        end
    end

`ifdef VCS_ZONE_HYST_EN
    logic [CW-1:0] hold_q, hold_d, cand_q, cand_d;
    logic          hvalid_q, hvalid_d, cvalid_q, cvalid_d, hyst_strobe;

    assign zone_sel    = hvalid_q ? hold_q : zone_ch;
    assign hyst_strobe = adc_done[safe_ch(zone_sel)];

    // A new zone channel must be seen on two consecutive selected strobes before it is adopted
    always_comb begin
        hold_d   = hold_q;
        cand_d   = cand_q;
        hvalid_d = hvalid_q;
        cvalid_d = cvalid_q;
        if (act_mode_q == 2'd1) begin
            if (!hvalid_q) begin
                hold_d   = zone_ch;
                hvalid_d = 1'b1;
                cvalid_d = 1'b0;
            end else if (hyst_strobe) begin
                if (zone_ch == hold_q) begin
                    cvalid_d = 1'b0;
                end else if (cvalid_q && (cand_q == zone_ch)) begin
                    hold_d   = zone_ch;
                    cvalid_d = 1'b0;
                end else begin
                    cand_d   = zone_ch;
                    cvalid_d = 1'b1;
                end
            end
        end
        if (bnd) begin
            hvalid_d = 1'b0;
            cvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q   <= '0;
            cand_q   <= '0;
            hvalid_q <= 1'b0;
            cvalid_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            cand_q   <= cand_d;
            hvalid_q <= hvalid_d;
            cvalid_q <= cvalid_d;
        end
    end
`else
    assign zone_sel = zone_ch;
`endif

    always_comb begin
        raw_sel = (act_mode_q == 2'd1) ? zone_sel : act_man_q;
        sel_ch  = safe_ch(raw_sel);
        bit_sel  = (act_mode_q == 2'd2) ? sim_bit : bits[sel_ch];
        done_sel = adc_done[sel_ch];
        cur_ch_d = sel_ch;
    end

    // The bit travels alongside its strobe so the hit test sees the bit latched at that strobe
    always_comb begin
        bit_pipe_d     = bit_pipe_q << 1;
        bit_pipe_d[0]  = bit_sel;
        done_pipe_d    = done_pipe_q << 1;
        done_pipe_d[0] = done_sel;
        hit            = done_pipe_q[DLY-1] & bit_pipe_q[DLY-1];
        cnt_inc        = (hit && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
        if (bnd) begin
            hit_cnt_d   = cnt_inc;
            hit_valid_d = 1'b1;
            cnt_d       = '0;
        end else begin
            hit_cnt_d   = hit_cnt_q;
            hit_valid_d = 1'b0;
            cnt_d       = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_q        <= 1'b0;
            p2_q        <= 1'b0;
            for (int z = 0; z < NZ; z++) begin
                sh_bound_q[z]  <= '1;
                sh_ch_q[z]     <= '0;
                act_bound_q[z] <= '1;
                act_ch_q[z]    <= '0;
            end
            sh_mode_q   <= '0;
            sh_man_q    <= '0;
            act_mode_q  <= '0;
            act_man_q   <= '0;
            cur_ch_q    <= '0;
            bit_pipe_q  <= '0;
            done_pipe_q <= '0;
            cnt_q       <= '0;
            hit_cnt_q   <= '0;
            hit_valid_q <= 1'b0;
        end else begin
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            sh_bound_q  <= sh_bound_d;
            sh_ch_q     <= sh_ch_d;
            act_bound_q <= act_bound_d;
            act_ch_q    <= act_ch_d;
            sh_mode_q   <= sh_mode_d;
            sh_man_q    <= sh_man_d;
            act_mode_q  <= act_mode_d;
            act_man_q   <= act_man_d;
            cur_ch_q    <= cur_ch_d;
            bit_pipe_q  <= bit_pipe_d;
            done_pipe_q <= done_pipe_d;
            cnt_q       <= cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_valid_q <= hit_valid_d;
        end
    end

    assign bit_out   = bit_pipe_q[0];
    assign done_out  = done_pipe_q[DLY-1];
    assign cur_ch    = cur_ch_q;
    assign hit_cnt   = hit_cnt_q;
    assign hit_valid = hit_valid_q;

endmodule

// File: tb/tb_video_chan_select.sv
// Directed testbench for video_chan_select in its default build (zone hysteresis disabled).
module tb_video_chan_select;

    logic        clk = 1'b0;
    logic        reset;
    logic        pros;
    logic [9:0]  range;
    logic [3:0]  bits;
    logic [3:0]  adc_done;
    logic        sim_bit;
    logic        cfg_we;
    logic [1:0]  cfg_zone;
    logic [9:0]  cfg_bound;
    logic [1:0]  cfg_ch;
    logic [1:0]  mode;
    logic [1:0]  man_ch;
    logic        bit_out;
    logic        done_out;
    logic [1:0]  cur_ch;
    logic [15:0] hit_cnt;
    logic        hit_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    video_chan_select dut (
        .clk(clk), .reset(reset), .pros(pros), .range(range), .bits(bits),
        .adc_done(adc_done), .sim_bit(sim_bit), .cfg_we(cfg_we), .cfg_zone(cfg_zone),
        .cfg_bound(cfg_bound), .cfg_ch(cfg_ch), .mode(mode), .man_ch(man_ch),
        .bit_out(bit_out), .done_out(done_out), .cur_ch(cur_ch),
        .hit_cnt(hit_cnt), .hit_valid(hit_valid)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge; inputs change here, outputs are read here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic boundary();
        pros = 1'b1;
        tick();
        pros = 1'b0;
        tick();
        tick();
    endtask

    task automatic write_zone(input logic [1:0] z, input logic [9:0] b, input logic [1:0] c);
        cfg_we = 1'b1; cfg_zone = z; cfg_bound = b; cfg_ch = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; pros = 0; range = 0; bits = 0; adc_done = 0; sim_bit = 0;
        cfg_we = 0; cfg_zone = 0; cfg_bound = 0; cfg_ch = 0; mode = 0; man_ch = 0;
        tick();
        tests_run++; if (bit_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bit_out got %0b want 0", bit_out); end
        tests_run++; if (done_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done_out got %0b want 0", done_out); end
        tests_run++; if (cur_ch !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_cur_ch got %0d want 0", cur_ch); end
        tests_run++; if (hit_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_hit_cnt got %0d want 0", hit_cnt); end
        tests_run++; if (hit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hit_valid got %0b want 0", hit_valid); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_zone_lookup();
        logic [9:0] ranges [4];
        logic [1:0] exp_ch [4];
        ranges = '{10'd100, 10'd159, 10'd500, 10'd1023};
        exp_ch = '{2'd2, 2'd0, 2'd1, 2'd3};
        write_zone(2'd0, 10'd159, 2'd2);
        write_zone(2'd1, 10'd400, 2'd0);
        write_zone(2'd2, 10'd800, 2'd1);
        write_zone(2'd3, 10'd1023, 2'd3);
        mode = 2'd1;
        boundary();
        for (int i = 0; i < 4; i++) begin
            range = ranges[i];
            bits = 4'b0001 << exp_ch[i];
            adc_done = 4'b0001 << exp_ch[i];
            tick();
            tests_run++; if (cur_ch !== exp_ch[i]) begin tests_failed++; $display("[TB] FAIL zone_cur_ch range=%0d got %0d want %0d", ranges[i], cur_ch, exp_ch[i]); end
            tests_run++; if (bit_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL zone_bit_hi range=%0d got %0b want 1", ranges[i], bit_out); end
            bits = ~(4'b0001 << exp_ch[i]);
            tick();
            tests_run++; if (bit_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL zone_bit_lo range=%0d got %0b want 0", ranges[i], bit_out); end
        end
        adc_done = 0; bits = 0;
    endtask

    task automatic test_deferred_config();
        range = 10'd100;
        tick();
        write_zone(2'd0, 10'd159, 2'd1);
        tick();
        tests_run++; if (cur_ch !== 2'd2) begin tests_failed++; $display("[TB] FAIL defer_midsweep got %0d want 2", cur_ch); end
        pros = 1'b1; tick();
        pros = 1'b0; tick();
        tests_run++; if (cur_ch !== 2'd2) begin tests_failed++; $display("[TB] FAIL defer_before_bnd got %0d want 2", cur_ch); end
        tick();
        tick();
        tests_run++; if (cur_ch !== 2'd1) begin tests_failed++; $display("[TB] FAIL defer_after_bnd got %0d want 1", cur_ch); end
        // Write lands on the boundary cycle itself
        pros = 1'b1; tick();
        pros = 1'b0; tick();
        write_zone(2'd0, 10'd159, 2'd3);
        tick();
        tests_run++; if (cur_ch !== 2'd1) begin tests_failed++; $display("[TB] FAIL defer_coincident got %0d want 1", cur_ch); end
        boundary();
        tick();
        tests_run++; if (cur_ch !== 2'd3) begin tests_failed++; $display("[TB] FAIL defer_next_bnd got %0d want 3", cur_ch); end
    endtask

    task automatic test_done_latency();
        logic exp_seq [5];
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        mode = 2'd0; man_ch = 2'd1;
        boundary();
        tick(); tick(); tick(); tick();
        adc_done = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) adc_done = 4'b0000;
            tick();
            tests_run++; if (done_out !== exp_seq[i]) begin tests_failed++; $display("[TB] FAIL done_latency cycle=%0d got %0b want %0b", i + 1, done_out, exp_seq[i]); end
        end
        adc_done = 4'b1101;
        tick();
        adc_done = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (done_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_unselected cycle=%0d got %0b want 0", i, done_out); end
        end
    endtask

    task automatic test_hit_count();
        boundary();
        for (int i = 0; i < 37; i++) begin
            bits = 4'b0010; adc_done = 4'b0010; tick();
        end
        for (int i = 0; i < 20; i++) begin
            bits = 4'b0000; adc_done = 4'b0010; tick();
        end
        bits = 0; adc_done = 0;
        for (int i = 0; i < 5; i++) tick();
        tests_run++; if (hit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_valid_idle got %0b want 0", hit_valid); end
        boundary();
        tests_run++; if (hit_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hit_valid_pulse got %0b want 1", hit_valid); end
        tests_run++; if (hit_cnt !== 16'd37) begin tests_failed++; $display("[TB] FAIL hit_cnt_37 got %0d want 37", hit_cnt); end
        tick();
        tests_run++; if (hit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_valid_width got %0b want 0", hit_valid); end
        boundary();
        tests_run++; if (hit_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL hit_cnt_cleared got %0d want 0", hit_cnt); end
        bits = 4'b0010; adc_done = 4'b0010;
        for (int i = 0; i < 70000; i++) tick();
        bits = 0; adc_done = 0;
        for (int i = 0; i < 5; i++) tick();
        boundary();
        tests_run++; if (hit_cnt !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL hit_cnt_saturate got %0h want ffff", hit_cnt); end
    endtask

    task automatic test_simulate();
        logic pattern [6];
        pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        mode = 2'd2; man_ch = 2'd1; bits = 4'b0000;
        boundary();
        for (int i = 0; i < 6; i++) begin
            sim_bit = pattern[i];
            tick();
            tests_run++; if (bit_out !== pattern[i]) begin tests_failed++; $display("[TB] FAIL sim_bit step=%0d got %0b want %0b", i, bit_out, pattern[i]); end
        end
        tests_run++; if (cur_ch !== 2'd1) begin tests_failed++; $display("[TB] FAIL sim_cur_ch got %0d want 1", cur_ch); end
        sim_bit = 0;
    endtask

    task automatic test_reset_mid_sweep();
        mode = 2'd0; man_ch = 2'd1;
        boundary();
        for (int i = 0; i < 5; i++) begin
            bits = 4'b0010; adc_done = 4'b0010; tick();
        end
        bits = 0; adc_done = 0;
        for (int i = 0; i < 5; i++) tick();
        boundary();
        tests_run++; if (hit_cnt !== 16'd5) begin tests_failed++; $display("[TB] FAIL premid_hit_cnt got %0d want 5", hit_cnt); end
        bits = 4'b0010; adc_done = 4'b0010;
        tick(); tick();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        tests_run++; if (cur_ch !== 2'd0) begin tests_failed++; $display("[TB] FAIL rst_cur_ch got %0d want 0", cur_ch); end
        tests_run++; if (hit_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL rst_hit_cnt got %0d want 0", hit_cnt); end
        tests_run++; if (done_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_done_out got %0b want 0", done_out); end
        tests_run++; if (bit_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_bit_out got %0b want 0", bit_out); end
        bits = 0; adc_done = 0;
        tick();
        reset = 1'b1;
        mode = 2'd1; man_ch = 2'd2; range = 10'd500;
        tick();
        boundary();
        tick();
        tests_run++; if (cur_ch !== 2'd0) begin tests_failed++; $display("[TB] FAIL rst_table_default got %0d want 0", cur_ch); end
        tests_run++; if (hit_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL rst_first_sweep got %0d want 0", hit_cnt); end
    endtask

    initial begin
        test_reset();
        test_zone_lookup();
        test_deferred_config();
        test_done_latency();
        test_hit_count();
        test_simulate();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
